// File: rtl/aurora_simplex_tx_ctrl_if.sv
// Transmit-side handshake/lane bundle between the simplex TX controller and
// the AXI ingress / lane encoders.
//   axi_valid : upstream data valid (driven by the ingress side)
//   axi_ready : upstream may transfer this cycle (driven by the controller)
//   tx_cmd    : block command to encoders (0 IDLE,1 ALIGN,2 BOND,3 VERIFY,4 DATA,5 CC)
//   lane_en   : active lane mask to encoders
// master = controller side, slave = ingress/encoder side.
interface aurora_simplex_tx_ctrl_if #(
  parameter int MAX_LINKS = 2
) ();
  logic                 axi_valid;
  logic                 axi_ready;
  logic [2:0]           tx_cmd;
  logic [MAX_LINKS-1:0] lane_en;

  modport master (input axi_valid, output axi_ready, output tx_cmd, output lane_en);
  modport slave  (output axi_valid, input axi_ready, input tx_cmd, input lane_en);
endinterface

// File: rtl/aurora_simplex_tx_ctrl.sv
// Aurora simplex TX controller: sequences RESET/ALIGN/BOND/VERIFY, drives the
// simplex sideband status, gates AXI-Stream acceptance and inserts periodic
// clock-compensation bursts once the channel is up. All outputs registered.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   i_single_lane     : 1 = single-lane mode (lowest requested lane, no BOND)
//   i_lane_select     : requested lane mask
//   i_restart         : synchronous re-initialisation pulse
//   tx_if (master)    : axi_valid in; axi_ready, tx_cmd, lane_en out
//   o_simplex_*       : sideband reset/aligned/bonded/verified
//   o_channel_up      : channel in READY
//
// state    | meaning
// S_RESET  | simplex_reset high, lane mask latched, waits for nonzero mask
// S_ALIGN  | alignment blocks on enabled lanes
// S_BOND   | channel-bond blocks (multi-lane only)
// S_VERIFY | verification sequence
// S_READY  | data transfer with periodic CC bursts
module aurora_simplex_tx_ctrl #(
  parameter int MAX_LINKS     = 2,
  parameter int RESET_CYCLES  = 16,
  parameter int ALIGN_CYCLES  = 64,
  parameter int BOND_CYCLES   = 32,
  parameter int VERIFY_CYCLES = 64,
  parameter int CC_PERIOD     = 5000,
  parameter int CC_LEN        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_single_lane,
  input  logic [MAX_LINKS-1:0]  i_lane_select,
  input  logic                  i_restart,
  aurora_simplex_tx_ctrl_if.master tx_if,
  output logic                  o_simplex_reset,
  output logic                  o_simplex_aligned,
  output logic                  o_simplex_bonded,
  output logic                  o_simplex_verified,
  output logic                  o_channel_up
);

  localparam int MAX_RA = (RESET_CYCLES > ALIGN_CYCLES) ? RESET_CYCLES : ALIGN_CYCLES;
  localparam int MAX_BV = (BOND_CYCLES > VERIFY_CYCLES) ? BOND_CYCLES : VERIFY_CYCLES;
  localparam int MAXC   = (MAX_RA > MAX_BV) ? MAX_RA : MAX_BV;
  localparam int CW     = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam int CCW    = (CC_PERIOD > 2) ? $clog2(CC_PERIOD) : 1;
  localparam int RW     = $clog2(CC_LEN + 1);

  localparam logic [2:0] CMD_IDLE   = 3'd0;
  localparam logic [2:0] CMD_ALIGN  = 3'd1;
  localparam logic [2:0] CMD_BOND   = 3'd2;
  localparam logic [2:0] CMD_VERIFY = 3'd3;
  localparam logic [2:0] CMD_DATA   = 3'd4;
  localparam logic [2:0] CMD_CC     = 3'd5;

  typedef enum logic [2:0] {S_RESET, S_ALIGN, S_BOND, S_VERIFY, S_READY} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_first;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [CCW-1:0]       r_cc_cnt, w_cc_cnt_nxt;
  logic [RW-1:0]        r_cc_rem, w_cc_rem_nxt;
  logic [MAX_LINKS-1:0] r_mask, w_mask_nxt;
  logic [MAX_LINKS-1:0] r_lane_sel, w_lane_sel_nxt;
  logic                 r_single, w_single_nxt;
  logic [2:0]           r_tx_cmd, w_tx_cmd_nxt;
  logic [MAX_LINKS-1:0] r_lane_en, w_lane_en_nxt;
  logic                 r_reset, w_reset_nxt;
  logic                 r_aligned, w_aligned_nxt;
  logic                 r_bonded, w_bonded_nxt;
  logic                 r_verified, w_verified_nxt;
  logic                 r_chup, w_chup_nxt;
  logic                 r_axi_ready, w_axi_ready_nxt;
  logic [MAX_LINKS-1:0] w_eff_mask;
  logic                 w_reinit;

  // Single-lane mode keeps only the lowest requested lane.
  assign w_eff_mask = i_single_lane ? (i_lane_select & (~i_lane_select + MAX_LINKS'(1)))
                                    : i_lane_select;
  assign w_reinit   = i_restart ||
                      ((r_state != S_RESET) &&
                       ((i_lane_select != r_lane_sel) || (i_single_lane != r_single)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET;
      r_first     <= 1'b1;
      r_cnt       <= '0;
      r_cc_cnt    <= '0;
      r_cc_rem    <= '0;
      r_mask      <= '0;
      r_lane_sel  <= '0;
      r_single    <= 1'b0;
      r_tx_cmd    <= CMD_IDLE;
      r_lane_en   <= '0;
      r_reset     <= 1'b1;
      r_aligned   <= 1'b0;
      r_bonded    <= 1'b0;
      r_verified  <= 1'b0;
      r_chup      <= 1'b0;
      r_axi_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_first     <= 1'b0;
      r_cnt       <= w_cnt_nxt;
      r_cc_cnt    <= w_cc_cnt_nxt;
      r_cc_rem    <= w_cc_rem_nxt;
      r_mask      <= w_mask_nxt;
      r_lane_sel  <= w_lane_sel_nxt;
      r_single    <= w_single_nxt;
      r_tx_cmd    <= w_tx_cmd_nxt;
      r_lane_en   <= w_lane_en_nxt;
      r_reset     <= w_reset_nxt;
      r_aligned   <= w_aligned_nxt;
      r_bonded    <= w_bonded_nxt;
      r_verified  <= w_verified_nxt;
      r_chup      <= w_chup_nxt;
      r_axi_ready <= w_axi_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cc_cnt_nxt   = r_cc_cnt;
    w_cc_rem_nxt   = r_cc_rem;
    w_mask_nxt     = r_mask;
    w_lane_sel_nxt = r_lane_sel;
    w_single_nxt   = r_single;
    w_aligned_nxt  = r_aligned;
    w_bonded_nxt   = r_bonded;
    w_verified_nxt = r_verified;
    w_chup_nxt     = r_chup;

    if (w_reinit) begin
      w_state_nxt    = S_RESET;
      w_cnt_nxt      = CW'(RESET_CYCLES - 1);
      w_cc_cnt_nxt   = '0;
      w_cc_rem_nxt   = '0;
      w_mask_nxt     = w_eff_mask;
      w_lane_sel_nxt = i_lane_select;
      w_single_nxt   = i_single_lane;
      w_aligned_nxt  = 1'b0;
      w_bonded_nxt   = 1'b0;
      w_verified_nxt = 1'b0;
      w_chup_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          // Mask keeps tracking the inputs while held in reset.
          w_mask_nxt     = w_eff_mask;
          w_lane_sel_nxt = i_lane_select;
          w_single_nxt   = i_single_lane;
          // Counter comes out of async reset at 0; the first cycle counts
          // as one of the reset cycles, so load one less.
          if (r_first) begin
            w_cnt_nxt = CW'(RESET_CYCLES - 2);
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else if (w_eff_mask != '0) begin
            w_state_nxt = S_ALIGN;
            w_cnt_nxt   = CW'(ALIGN_CYCLES - 1);
          end
        end
        S_ALIGN: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_aligned_nxt = 1'b1;
            if (r_single) begin
              w_bonded_nxt = 1'b1;
              w_state_nxt  = S_VERIFY;
              w_cnt_nxt    = CW'(VERIFY_CYCLES - 1);
            end else begin
              w_state_nxt  = S_BOND;
              w_cnt_nxt    = CW'(BOND_CYCLES - 1);
            end
          end
        end
        S_BOND: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_bonded_nxt = 1'b1;
            w_state_nxt  = S_VERIFY;
            w_cnt_nxt    = CW'(VERIFY_CYCLES - 1);
          end
        end
        S_VERIFY: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_verified_nxt = 1'b1;
            w_chup_nxt     = 1'b1;
            w_state_nxt    = S_READY;
            w_cc_cnt_nxt   = '0;
            w_cc_rem_nxt   = '0;
          end
        end
        S_READY: begin
          // r_cc_rem counts CC cycles left including the current one.
          if (r_cc_cnt == CCW'(CC_PERIOD - 1)) begin
            w_cc_cnt_nxt = '0;
            w_cc_rem_nxt = RW'(CC_LEN);
          end else begin
            w_cc_cnt_nxt = r_cc_cnt + CCW'(1);
            if (r_cc_rem != '0) w_cc_rem_nxt = r_cc_rem - RW'(1);
          end
        end
        default: w_state_nxt = S_RESET;
      endcase
    end

    // Registered outputs are derived from the next-state values so they
    // line up with the state they describe.
    w_reset_nxt     = (w_state_nxt == S_RESET);
    w_lane_en_nxt   = w_reset_nxt ? '0 : w_mask_nxt;
    w_axi_ready_nxt = (w_state_nxt == S_READY) && (w_cc_rem_nxt == '0);
    w_tx_cmd_nxt    = CMD_IDLE;
    case (w_state_nxt)
      S_ALIGN:  w_tx_cmd_nxt = CMD_ALIGN;
      S_BOND:   w_tx_cmd_nxt = CMD_BOND;
      S_VERIFY: w_tx_cmd_nxt = CMD_VERIFY;
      S_READY: begin
        if (w_cc_rem_nxt != '0)                    w_tx_cmd_nxt = CMD_CC;
        else if (tx_if.axi_valid && w_axi_ready_nxt) w_tx_cmd_nxt = CMD_DATA;
      end
      default:  w_tx_cmd_nxt = CMD_IDLE;
    endcase
  end

  assign tx_if.axi_ready    = r_axi_ready;
  assign tx_if.tx_cmd       = r_tx_cmd;
  assign tx_if.lane_en      = r_lane_en;
  assign o_simplex_reset    = r_reset;
  assign o_simplex_aligned  = r_aligned;
  assign o_simplex_bonded   = r_bonded;
  assign o_simplex_verified = r_verified;
  assign o_channel_up       = r_chup;

endmodule

// File: tb/tb_aurora_simplex_tx_ctrl.sv
module tb_aurora_simplex_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       single_lane = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] lane_select = 2'b11;
  logic       sr, al, bo, ve, up;
  int         n_checks = 0;
  int         n_fail = 0;

  aurora_simplex_tx_ctrl_if #(.MAX_LINKS(2)) tx_if ();

  aurora_simplex_tx_ctrl #(.MAX_LINKS(2), .CC_PERIOD(20), .CC_LEN(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_single_lane      (single_lane),
    .i_lane_select      (lane_select),
    .i_restart          (restart),
    .tx_if              (tx_if),
    .o_simplex_reset    (sr),
    .o_simplex_aligned  (al),
    .o_simplex_bonded   (bo),
    .o_simplex_verified (ve),
    .o_channel_up       (up)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         steps;
    logic       sl;
    logic [1:0] sel;
    logic       vld;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] pk(logic [2:0] c, logic [1:0] l, logic r, logic a,
                                    logic b, logic v, logic u, logic y);
    return {c, l, r, a, b, v, u, y};
  endfunction

  task automatic add(int steps, logic sl, logic [1:0] sel, logic vld, logic [9:0] e, string nm);
    vec_t v;
    v.steps = steps; v.sl = sl; v.sel = sel; v.vld = vld; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [9:0] e);
    logic [9:0] a;
    a = {tx_if.tx_cmd, tx_if.lane_en, sr, al, bo, ve, up, tx_if.axi_ready};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got cmd=%0d lane_en=%b rst/al/bo/ve/up/rdy=%b, want cmd=%0d lane_en=%b rst/al/bo/ve/up/rdy=%b",
               nm, a[9:7], a[6:5], a[4:0], e[9:7], e[6:5], e[4:0]);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  logic [9:0] RST_V;
  logic       cc;

  initial begin
    RST_V = pk(3'd0, 2'b00, 1, 0, 0, 0, 0, 0);
    tx_if.axi_valid = 1'b1;

    // Dual-lane bring-up, CC schedule, idle, lane change in READY.
    add(0,   0, 2'b11, 1, RST_V,                              "reset_values");
    add(15,  0, 2'b11, 1, RST_V,                              "reset_last");
    add(1,   0, 2'b11, 1, pk(3'd1, 2'b11, 0, 0, 0, 0, 0, 0), "align_first");
    add(63,  0, 2'b11, 1, pk(3'd1, 2'b11, 0, 0, 0, 0, 0, 0), "align_last");
    add(1,   0, 2'b11, 1, pk(3'd2, 2'b11, 0, 1, 0, 0, 0, 0), "bond_first");
    add(31,  0, 2'b11, 1, pk(3'd2, 2'b11, 0, 1, 0, 0, 0, 0), "bond_last");
    add(1,   0, 2'b11, 1, pk(3'd3, 2'b11, 0, 1, 1, 0, 0, 0), "verify_first");
    add(63,  0, 2'b11, 1, pk(3'd3, 2'b11, 0, 1, 1, 0, 0, 0), "verify_last");
    add(1,   0, 2'b11, 1, pk(3'd4, 2'b11, 0, 1, 1, 1, 1, 1), "ready_at_176");
    add(19,  0, 2'b11, 1, pk(3'd4, 2'b11, 0, 1, 1, 1, 1, 1), "data_before_cc");
    add(1,   0, 2'b11, 1, pk(3'd5, 2'b11, 0, 1, 1, 1, 1, 0), "cc1_first");
    add(2,   0, 2'b11, 1, pk(3'd5, 2'b11, 0, 1, 1, 1, 1, 0), "cc1_last");
    add(1,   0, 2'b11, 1, pk(3'd4, 2'b11, 0, 1, 1, 1, 1, 1), "data_after_cc1");
    add(17,  0, 2'b11, 1, pk(3'd5, 2'b11, 0, 1, 1, 1, 1, 0), "cc2_first");
    add(2,   0, 2'b11, 1, pk(3'd5, 2'b11, 0, 1, 1, 1, 1, 0), "cc2_last");
    add(1,   0, 2'b11, 1, pk(3'd4, 2'b11, 0, 1, 1, 1, 1, 1), "data_after_cc2");
    add(1,   0, 2'b11, 0, pk(3'd0, 2'b11, 0, 1, 1, 1, 1, 1), "idle_no_valid");
    add(1,   0, 2'b11, 1, pk(3'd4, 2'b11, 0, 1, 1, 1, 1, 1), "data_resume");
    add(1,   0, 2'b01, 1, RST_V,                              "lane_change_reset");
    add(15,  0, 2'b01, 1, RST_V,                              "reinit_reset_last");
    add(1,   0, 2'b01, 1, pk(3'd1, 2'b01, 0, 0, 0, 0, 0, 0), "reinit_align_mask01");

    single_lane = 1'b0; lane_select = 2'b11;
    do_reset();
    foreach (vecs[i]) begin
      single_lane     = vecs[i].sl;
      lane_select     = vecs[i].sel;
      tx_if.axi_valid = vecs[i].vld;
      step(vecs[i].steps);
      chk(vecs[i].name, vecs[i].exp);
    end

    // Single-lane: lowest lane only, BOND skipped, bonded with aligned.
    single_lane = 1'b1; lane_select = 2'b11; tx_if.axi_valid = 1'b1;
    do_reset();
    step(16); chk("sl_align", pk(3'd1, 2'b01, 0, 0, 0, 0, 0, 0));
    step(63); chk("sl_align_last", pk(3'd1, 2'b01, 0, 0, 0, 0, 0, 0));
    step(1);  chk("sl_verify", pk(3'd3, 2'b01, 0, 1, 1, 0, 0, 0));
    step(63); chk("sl_verify_last", pk(3'd3, 2'b01, 0, 1, 1, 0, 0, 0));
    step(1);  chk("sl_ready", pk(3'd4, 2'b01, 0, 1, 1, 1, 1, 1));

    // Zero mask holds RESET; a nonzero mask then lets init proceed.
    single_lane = 1'b0; lane_select = 2'b00;
    do_reset();
    step(40); chk("zero_mask_hold", RST_V);
    lane_select = 2'b10;
    step(1);  chk("zero_mask_release", pk(3'd1, 2'b10, 0, 0, 0, 0, 0, 0));

    // READY with mask 01: full CC schedule scan, then lane change 01->11.
    lane_select = 2'b01;
    do_reset();
    step(176); chk("m01_ready", pk(3'd4, 2'b01, 0, 1, 1, 1, 1, 1));
    for (int k = 1; k < 60; k++) begin
      step(1);
      cc = (k >= 20) && ((k % 20) < 3);
      chk($sformatf("cc_sched_k%0d", k),
          pk(cc ? 3'd5 : 3'd4, 2'b01, 0, 1, 1, 1, 1, !cc));
    end
    lane_select = 2'b11;
    step(1);  chk("m11_change_reset", RST_V);
    step(16); chk("m11_align", pk(3'd1, 2'b11, 0, 0, 0, 0, 0, 0));

    // Restart pulse in ALIGN, then restart in RESET reloads the timer.
    step(5);
    restart = 1'b1; step(1); restart = 1'b0;
    chk("restart_in_align", RST_V);
    step(10);
    restart = 1'b1; step(1); restart = 1'b0;
    chk("restart_in_reset", RST_V);
    step(15); chk("reload_reset_last", RST_V);
    step(1);  chk("reload_align", pk(3'd1, 2'b11, 0, 0, 0, 0, 0, 0));

    // Async reset during VERIFY takes effect before the next clock edge.
    step(100); chk("pre_async_verify", pk(3'd3, 2'b11, 0, 1, 1, 0, 0, 0));
    rst_n = 1'b0;
    #1 chk("async_reset_mid_cycle", RST_V);
    #2 rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
